// File: rtl/pipe_stage_skid.sv
// Purpose: inter-stage pipeline register with valid/ready handshake, 1-entry skid, hold and flush.
// Latency: 1 cycle from accept to out_*; sustains one transfer per cycle.
// Backpressure: in_ready is a pure register, low when the skid is full or a flush is pending.
module pipe_stage_skid #(
  parameter int                PC_W    = 32,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
);

  // Skid entry holds the one transfer that arrived while main was stalled.
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  // A flush seen during hold is parked here until hold drops.
  logic              flush_pend;

  logic              out_valid_n;
  logic [PC_W-1:0]   out_pc_n;
  logic [DATA_W-1:0] out_data_n;
  logic              skid_valid_n;
  logic [PC_W-1:0]   skid_pc_n;
  logic [DATA_W-1:0] skid_data_n;
  logic              flush_pend_n;
  logic              in_ready_n;

  logic acc;
  logic deq;

  assign acc = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  // Next-state: hold freezes everything but flush capture; flush clears; otherwise handshake.
  always_comb begin
    out_valid_n  = out_valid;
    out_pc_n     = out_pc;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_data_n  = skid_data;
    flush_pend_n = flush_pend;

    if (hold) begin
      flush_pend_n = flush_pend || flush;
    end else if (flush || flush_pend) begin
      // Input side is discarded on this edge as well.
      out_valid_n  = 1'b0;
      out_pc_n     = '0;
      out_data_n   = NOP_VAL;
      skid_valid_n = 1'b0;
      flush_pend_n = 1'b0;
    end else if (!out_valid || deq) begin
      if (skid_valid) begin
        // in_ready was low, so nothing can be accepted alongside this refill.
        out_valid_n  = 1'b1;
        out_pc_n     = skid_pc;
        out_data_n   = skid_data;
        skid_valid_n = 1'b0;
      end else if (acc) begin
        out_valid_n = 1'b1;
        out_pc_n    = in_pc;
        out_data_n  = in_data;
      end else begin
        // Empty main always presents a NOP bubble.
        out_valid_n = 1'b0;
        out_pc_n    = '0;
        out_data_n  = NOP_VAL;
      end
    end else if (acc) begin
      skid_valid_n = 1'b1;
      skid_pc_n    = in_pc;
      skid_data_n  = in_data;
    end

    in_ready_n = !skid_valid_n && !flush_pend_n;
  end

  // State register with synchronous active-low reset that overrides hold and flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_data   <= NOP_VAL;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_data  <= NOP_VAL;
      flush_pend <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_n;
      out_pc     <= out_pc_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_data  <= skid_data_n;
      flush_pend <= flush_pend_n;
      in_ready   <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Purpose: directed table of single-edge vectors plus a handshake ordering sequence.
// Latency: expectations are the values visible just after each clock edge.
// Backpressure: exercised through out_ready patterns, hold and flush.
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_skid #(.PC_W(32), .DATA_W(32), .NOP_VAL(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        hold;
    logic        flush;
    logic        iv;
    logic [31:0] ipc;
    logic        ordy;
    logic        eov;
    logic [31:0] epc;
    logic        eir;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic h, input logic f, input logic iv,
                     input logic [31:0] ipc, input logic ordy,
                     input logic eov, input logic [31:0] epc, input logic eir);
    vec_t v;
    v.rst = r; v.hold = h; v.flush = f; v.iv = iv; v.ipc = ipc; v.ordy = ordy;
    v.eov = eov; v.epc = epc; v.eir = eir;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [39:0] iv_pat;
    logic [39:0] or_pat;
    logic [31:0] next_pc;
    logic        a;
    logic        d;
    logic [31:0] cap_pc;
    logic [31:0] cap_data;
    int          sent;
    int          got;

    //   rst h f iv ipc       ordy  eov epc       eir
    // Reset held two cycles with in_valid=1, then first entry one cycle later.
    add(0, 0, 0, 1, 32'h100, 0,    0, 32'h0,    1);
    add(0, 0, 0, 1, 32'h100, 0,    0, 32'h0,    1);
    add(1, 0, 0, 1, 32'h100, 0,    1, 32'h100,  1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);
    // Streaming 8 back-to-back entries.
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 1, 32'(i * 4), 1, 1, 32'(i * 4), 1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);
    // Backpressure: 0x48 waits upstream while skid is full.
    add(1, 0, 0, 1, 32'h40,  0,    1, 32'h40,   1);
    add(1, 0, 0, 1, 32'h44,  0,    1, 32'h40,   0);
    add(1, 0, 0, 1, 32'h48,  0,    1, 32'h40,   0);
    add(1, 0, 0, 1, 32'h48,  1,    1, 32'h44,   1);
    add(1, 0, 0, 1, 32'h48,  1,    1, 32'h48,   1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);
    // Hold for 3 cycles with both sides willing.
    add(1, 0, 0, 1, 32'h60,  0,    1, 32'h60,   1);
    add(1, 1, 0, 1, 32'h64,  1,    1, 32'h60,   1);
    add(1, 1, 0, 1, 32'h64,  1,    1, 32'h60,   1);
    add(1, 1, 0, 1, 32'h64,  1,    1, 32'h60,   1);
    // Flush with two entries held; skid must be gone afterwards too.
    add(1, 0, 0, 1, 32'h64,  0,    1, 32'h60,   0);
    add(1, 0, 1, 1, 32'h68,  1,    0, 32'h0,    1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);
    // Flush during hold: remembered, applied when hold drops, input discarded.
    add(1, 0, 0, 1, 32'h80,  0,    1, 32'h80,   1);
    add(1, 1, 1, 1, 32'h84,  1,    1, 32'h80,   0);
    add(1, 1, 0, 1, 32'h84,  1,    1, 32'h80,   0);
    add(1, 1, 0, 1, 32'h84,  1,    1, 32'h80,   0);
    add(1, 0, 0, 1, 32'h84,  0,    0, 32'h0,    1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);
    // Reset during hold with a pending flush clears the pending flush.
    add(1, 0, 0, 1, 32'hA0,  0,    1, 32'hA0,   1);
    add(1, 1, 1, 0, 32'h0,   0,    1, 32'hA0,   0);
    add(0, 1, 0, 0, 32'h0,   0,    0, 32'h0,    1);
    add(1, 0, 0, 1, 32'hA4,  0,    1, 32'hA4,   1);
    add(1, 0, 0, 0, 32'h0,   1,    0, 32'h0,    1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; hold = vecs[i].hold; flush = vecs[i].flush;
      in_valid = vecs[i].iv; in_pc = vecs[i].ipc; in_data = data_of(vecs[i].ipc);
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
      check($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
      check($sformatf("v%0d out_data", i), out_data, vecs[i].eov ? data_of(vecs[i].epc) : NOP);
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
    end

    // Mixed valid/ready interleaving: order preserved, no drop or duplicate.
    iv_pat  = 40'hF7_BD_EF_7B_DF;
    or_pat  = 40'hC5_3A_96_0F_E1;
    next_pc = 32'h1000;
    sent    = 0;
    got     = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      hold = 1'b0; flush = 1'b0; rst = 1'b1;
      in_valid  = (c < 40) ? iv_pat[c] : 1'b0;
      out_ready = (c < 40) ? or_pat[c] : 1'b1;
      in_pc     = next_pc;
      in_data   = data_of(next_pc);
      #1;
      a = in_valid && in_ready;
      d = out_valid && out_ready;
      cap_pc = out_pc;
      cap_data = out_data;
      if (!out_valid) begin
        check($sformatf("seq c%0d bubble pc", c), out_pc, 32'h0);
        check($sformatf("seq c%0d bubble data", c), out_data, NOP);
      end
      if (d) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL seq c%0d unexpected output pc %08h", c, cap_pc);
        end else begin
          check($sformatf("seq c%0d pc", c), cap_pc, exp_q[0]);
          check($sformatf("seq c%0d data", c), cap_data, data_of(exp_q[0]));
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (a) begin
        exp_q.push_back(next_pc);
        next_pc += 32'd4;
        sent++;
      end
      @(posedge clk);
    end
    check("seq drained", 32'(exp_q.size()), 32'd0);
    check("seq count", 32'(got), 32'(sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
